// File: rtl/stopwatch_control_if.sv
// stopwatch_control_if: panel buttons, chain wrap and sequencer controls between
// the front panel, the stopwatch sequencer and the digit chain / display mux.
interface stopwatch_control_if;
   logic start_stop_btn, lap_btn, clear_btn, chain_rollover;
   logic tick_inc, count_clear, display_hold, running, overflow;
   modport master(
      output start_stop_btn, lap_btn, clear_btn, chain_rollover,
      input  tick_inc, count_clear, display_hold, running, overflow
   );
   modport slave(
      input  start_stop_btn, lap_btn, clear_btn, chain_rollover,
      output tick_inc, count_clear, display_hold, running, overflow
   );
endinterface

// File: rtl/stopwatch_control.sv
// stopwatch_control: run/pause/lap/clear sequencer with tick prescaler, lap hold and
// sticky overflow for a cascaded digit counter chain.
module stopwatch_control #(
   parameter int TICK_DIV     = 100000,
   parameter bit STOP_ON_WRAP = 1'b1
) (
   input logic clk,
   input logic reset,
   stopwatch_control_if.slave bus
);
   localparam int div_w = $clog2(TICK_DIV);
   localparam logic [div_w-1:0] div_max = div_w'(TICK_DIV - 1);
   typedef enum logic [2:0] {IDLE, RUNNING, LAP, PAUSED, DONE} state_t;
   state_t state, state_nx;
   logic [2:0] btn_q;
   logic [div_w-1:0] div_cnt;
   logic start_e, lap_e, clear_e, counting, overflow_q, count_clear_q;
   assign start_e = bus.start_stop_btn & ~btn_q[0];
   assign lap_e = bus.lap_btn & ~btn_q[1];
   assign clear_e = bus.clear_btn & ~btn_q[2];
   assign counting = (state == RUNNING) || (state == LAP);
   // clear beats wrap beats start beats lap
   always_comb begin
      state_nx = state;
      if (clear_e)
         state_nx = IDLE;
      else if (bus.chain_rollover && STOP_ON_WRAP)
         state_nx = DONE;
      else if (start_e)
         state_nx = (state == IDLE || state == PAUSED) ? RUNNING : counting ? PAUSED : state;
      else if (lap_e)
         state_nx = (state == RUNNING) ? LAP : (state == LAP) ? RUNNING : state;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         btn_q <= '0;
         div_cnt <= '0;
         overflow_q <= 1'b0;
         count_clear_q <= 1'b0;
      end else begin
         btn_q <= {bus.clear_btn, bus.lap_btn, bus.start_stop_btn};
         count_clear_q <= clear_e;
         overflow_q <= clear_e ? 1'b0 : (overflow_q | bus.chain_rollover);
         div_cnt <= (clear_e || state == IDLE) ? '0 :
                    !counting ? div_cnt :
                    (div_cnt == div_max) ? '0 : div_cnt + 1'b1;
      end
   // count_clear lands in the cycle after the edge, when the state is already IDLE
   assign bus.count_clear = count_clear_q;
   assign bus.tick_inc = counting && (div_cnt == div_max);
   assign bus.display_hold = (state == LAP);
   assign bus.running = counting;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_control.sv
// tb_stopwatch_control: directed stimulus with a per-DUT expected-pulse queue; monitors
// pop and compare whenever tick_inc or count_clear is seen.
module tb_stopwatch_control;
   typedef struct {
      bit clr;
      int cyc;
      bit run;
      bit hold;
      bit ovf;
   } ev_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int base;
   ev_t qa[$];
   ev_t qb[$];
   ev_t ea, eb;
   stopwatch_control_if a();
   stopwatch_control_if b();
   stopwatch_control #(.TICK_DIV(4), .STOP_ON_WRAP(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(a));
   stopwatch_control #(.TICK_DIV(4), .STOP_ON_WRAP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(b));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (!reset && (a.tick_inc || a.count_clear)) begin
         checks++;
         if (qa.size() == 0) begin
            failures++;
            $display("FAIL a_unexpected_pulse cyc=%0d tick=%b clr=%b want=none", cyc, a.tick_inc, a.count_clear);
         end else begin
            ea = qa.pop_front();
            if (ea.cyc != cyc || a.count_clear !== ea.clr || a.tick_inc !== !ea.clr || a.running !== ea.run ||
                a.display_hold !== ea.hold || a.overflow !== ea.ovf) begin
               failures++;
               $display("FAIL a_pulse got cyc=%0d tick=%b clr=%b run=%b hold=%b ovf=%b want cyc=%0d clr=%b run=%b hold=%b ovf=%b",
                        cyc, a.tick_inc, a.count_clear, a.running, a.display_hold, a.overflow,
                        ea.cyc, ea.clr, ea.run, ea.hold, ea.ovf);
            end
         end
      end
   always @(negedge clk)
      if (!reset && (b.tick_inc || b.count_clear)) begin
         checks++;
         if (qb.size() == 0) begin
            failures++;
            $display("FAIL b_unexpected_pulse cyc=%0d tick=%b clr=%b want=none", cyc, b.tick_inc, b.count_clear);
         end else begin
            eb = qb.pop_front();
            if (eb.cyc != cyc || b.count_clear !== eb.clr || b.tick_inc !== !eb.clr || b.running !== eb.run ||
                b.display_hold !== eb.hold || b.overflow !== eb.ovf) begin
               failures++;
               $display("FAIL b_pulse got cyc=%0d tick=%b clr=%b run=%b hold=%b ovf=%b want cyc=%0d clr=%b run=%b hold=%b ovf=%b",
                        cyc, b.tick_inc, b.count_clear, b.running, b.display_hold, b.overflow,
                        eb.cyc, eb.clr, eb.run, eb.hold, eb.ovf);
            end
         end
      end
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic push(input bit to_b, input bit clr, input int c, input bit run, input bit hold, input bit ovf);
      ev_t e;
      e.clr = clr;
      e.cyc = c;
      e.run = run;
      e.hold = hold;
      e.ovf = ovf;
      if (to_b) qb.push_back(e);
      else qa.push_back(e);
   endtask
   task automatic chk(input string n, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b want=%b cyc=%0d", n, act, exp, cyc);
      end
   endtask
   task automatic chk_zero(input string n);
      chk({n, "_a_outs"}, a.tick_inc | a.count_clear | a.display_hold | a.running | a.overflow, 1'b0);
      chk({n, "_b_outs"}, b.tick_inc | b.count_clear | b.display_hold | b.running | b.overflow, 1'b0);
   endtask
   initial begin
      {a.start_stop_btn, a.lap_btn, a.clear_btn, a.chain_rollover} = '0;
      {b.start_stop_btn, b.lap_btn, b.clear_btn, b.chain_rollover} = '0;
      #1 reset = 1'b1;
      #1 chk_zero("reset");
      step(2);
      reset = 1'b0;
      step(1);
      chk_zero("post_reset");
      // run: ticks 4, 8, 12 cycles after entry
      base = cyc;
      a.start_stop_btn = 1'b1;
      push(0, 0, base + 4, 1, 0, 0);
      push(0, 0, base + 8, 1, 0, 0);
      push(0, 0, base + 12, 1, 0, 0);
      step(1);
      chk("run_after_start", a.running, 1'b1);
      a.start_stop_btn = 1'b0;
      step(13);
      // pause two counts into a tick, idle 10 cycles, resume
      a.start_stop_btn = 1'b1;
      step(1);
      a.start_stop_btn = 1'b0;
      chk("paused_running", a.running, 1'b0);
      step(10);
      base = cyc;
      a.start_stop_btn = 1'b1;
      push(0, 0, base + 2, 1, 0, 0);
      push(0, 0, base + 6, 1, 1, 0);
      push(0, 0, base + 10, 1, 1, 0);
      push(0, 0, base + 14, 1, 0, 0);
      step(1);
      a.start_stop_btn = 1'b0;
      chk("resumed_running", a.running, 1'b1);
      step(2);
      a.lap_btn = 1'b1;
      step(1);
      a.lap_btn = 1'b0;
      chk("lap_hold_on", a.display_hold, 1'b1);
      chk("lap_running", a.running, 1'b1);
      step(7);
      a.lap_btn = 1'b1;
      step(1);
      a.lap_btn = 1'b0;
      chk("lap2_hold_off", a.display_hold, 1'b0);
      step(3);
      a.start_stop_btn = 1'b1;
      step(1);
      a.start_stop_btn = 1'b0;
      step(2);
      a.lap_btn = 1'b1;
      step(1);
      a.lap_btn = 1'b0;
      chk("lap_in_paused_hold", a.display_hold, 1'b0);
      chk("lap_in_paused_run", a.running, 1'b0);
      // start and lap together from PAUSED: start wins
      step(2);
      a.start_stop_btn = 1'b1;
      a.lap_btn = 1'b1;
      push(0, 0, base + 24, 1, 0, 0);
      step(1);
      a.start_stop_btn = 1'b0;
      a.lap_btn = 1'b0;
      chk("start_lap_run", a.running, 1'b1);
      chk("start_lap_hold", a.display_hold, 1'b0);
      step(3);
      a.lap_btn = 1'b1;
      push(0, 0, base + 28, 1, 1, 0);
      step(1);
      a.lap_btn = 1'b0;
      chk("lap_again_hold", a.display_hold, 1'b1);
      step(3);
      a.start_stop_btn = 1'b1;
      step(1);
      a.start_stop_btn = 1'b0;
      chk("lap_pause_hold", a.display_hold, 1'b0);
      chk("lap_pause_run", a.running, 1'b0);
      step(1);
      a.start_stop_btn = 1'b1;
      push(0, 0, base + 34, 1, 0, 0);
      step(1);
      a.start_stop_btn = 1'b0;
      step(3);
      // clear with a 3-cycle start level held alongside
      a.start_stop_btn = 1'b1;
      a.clear_btn = 1'b1;
      push(0, 1, base + 36, 0, 0, 0);
      step(1);
      a.clear_btn = 1'b0;
      chk("clear_run", a.running, 1'b0);
      chk("clear_ovf", a.overflow, 1'b0);
      step(2);
      a.start_stop_btn = 1'b0;
      step(8);
      chk("clear_no_restart", a.running, 1'b0);
      // wrap with STOP_ON_WRAP=1
      base = cyc;
      a.start_stop_btn = 1'b1;
      push(0, 0, base + 4, 1, 0, 0);
      push(0, 0, base + 8, 1, 0, 0);
      step(1);
      a.start_stop_btn = 1'b0;
      step(7);
      a.chain_rollover = 1'b1;
      step(1);
      a.chain_rollover = 1'b0;
      chk("wrap_ovf", a.overflow, 1'b1);
      chk("wrap_done_run", a.running, 1'b0);
      step(5);
      a.start_stop_btn = 1'b1;
      step(1);
      a.start_stop_btn = 1'b0;
      a.lap_btn = 1'b1;
      step(1);
      a.lap_btn = 1'b0;
      chk("done_start_ignored", a.running, 1'b0);
      chk("done_lap_ignored", a.display_hold, 1'b0);
      step(14);
      chk("done_tick_low", a.tick_inc, 1'b0);
      chk("done_ovf_sticky", a.overflow, 1'b1);
      a.clear_btn = 1'b1;
      push(0, 1, cyc + 1, 0, 0, 0);
      step(1);
      a.clear_btn = 1'b0;
      chk("done_clear_ovf", a.overflow, 1'b0);
      step(2);
      // wrap and clear on the same cycle: clear wins
      base = cyc;
      a.start_stop_btn = 1'b1;
      push(0, 0, base + 4, 1, 0, 0);
      push(0, 1, base + 5, 0, 0, 0);
      step(1);
      a.start_stop_btn = 1'b0;
      step(3);
      a.chain_rollover = 1'b1;
      a.clear_btn = 1'b1;
      step(1);
      a.chain_rollover = 1'b0;
      a.clear_btn = 1'b0;
      chk("wrap_clear_ovf", a.overflow, 1'b0);
      chk("wrap_clear_run", a.running, 1'b0);
      step(3);
      // wrap with STOP_ON_WRAP=0 keeps counting, then async reset mid-LAP
      base = cyc;
      b.start_stop_btn = 1'b1;
      push(1, 0, base + 4, 1, 0, 0);
      push(1, 0, base + 8, 1, 0, 0);
      push(1, 0, base + 12, 1, 1, 1);
      step(1);
      b.start_stop_btn = 1'b0;
      step(7);
      b.chain_rollover = 1'b1;
      step(1);
      b.chain_rollover = 1'b0;
      chk("b_wrap_ovf", b.overflow, 1'b1);
      chk("b_wrap_running", b.running, 1'b1);
      step(2);
      b.lap_btn = 1'b1;
      step(1);
      b.lap_btn = 1'b0;
      chk("b_lap_hold", b.display_hold, 1'b1);
      step(4);
      chk("b_tick_before_reset", b.tick_inc, 1'b1);
      reset = 1'b1;
      #1 chk_zero("async_reset");
      step(2);
      reset = 1'b0;
      step(3);
      chk_zero("after_reset");
      chk("queues_drained", (qa.size() == 0 && qb.size() == 0), 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
